// File: rtl/xbar_serial_deframer.sv
// rtl/xbar_serial_deframer.sv - serial header/payload deframer feeding a first-word fall-through pair FIFO
module xbar_serial_deframer #(
    parameter int PACKET_WIDTH = 8,
    parameter int BIT_DIV      = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int GAP_LIMIT    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        serial_in,
    output logic                        pair_valid,
    input  logic                        pair_ready,
    output logic [PACKET_WIDTH-1:0]     pair_header,
    output logic [PACKET_WIDTH-1:0]     pair_payload,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy,
    output logic                        frame_err,
    output logic                        timeout_err,
    output logic                        overflow
);

    localparam int CW = $clog2(BIT_DIV);
    localparam int IW = $clog2(PACKET_WIDTH + 1);
    localparam int GW = $clog2(GAP_LIMIT + 1);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int NW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CW-1:0] BIT_LAST   = CW'(BIT_DIV - 1);
    localparam logic [CW-1:0] HALF_LAST  = CW'(BIT_DIV / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(PACKET_WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_LIMIT - 1);
    localparam logic [NW-1:0] FULL_COUNT = NW'(FIFO_DEPTH);

    localparam logic PH_HEADER  = 1'b0;
    localparam logic PH_PAYLOAD = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [PACKET_WIDTH-1:0] shift_q, shift_d;
    logic [PACKET_WIDTH-1:0] header_q, header_d;
    logic                    stop_wait_q, stop_wait_d;
    logic                    phase_q, phase_d;
    logic [CW-1:0]           gap_cyc_q, gap_cyc_d;
    logic [GW-1:0]           gap_bits_q, gap_bits_d;
    logic                    frame_err_q, frame_err_d;
    logic                    timeout_q, timeout_d;
    logic                    overflow_q, overflow_d;
    logic                    pair_done;
    logic                    line;

    logic [PACKET_WIDTH-1:0] hdr_mem [FIFO_DEPTH];
    logic [PACKET_WIDTH-1:0] pay_mem [FIFO_DEPTH];
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]           count_q;
    logic                    push, pop, full;

    assign line = sync2_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 1'b1;
        idx_d       = idx_q;
        shift_d     = shift_q;
        header_d    = header_q;
        stop_wait_d = stop_wait_q;
        phase_d     = phase_q;
        gap_cyc_d   = gap_cyc_q;
        gap_bits_d  = gap_bits_q;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        pair_done   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!line) begin
                    state_d = S_START;
                    idx_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d   = '0;
                    state_d = line ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d   = '0;
                    shift_d = {line, shift_q[PACKET_WIDTH-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (stop_wait_q) begin
                    // bad stop bit: hold off re-arming until the line has gone back high
                    cnt_d = '0;
                    if (line) begin
                        stop_wait_d = 1'b0;
                        state_d     = S_IDLE;
                    end
                end else if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (line) begin
                        state_d = S_IDLE;
                        if (phase_q == PH_HEADER) begin
                            header_d   = shift_q;
                            phase_d    = PH_PAYLOAD;
                            gap_cyc_d  = '0;
                            gap_bits_d = '0;
                        end else begin
                            pair_done = 1'b1;
                            phase_d   = PH_HEADER;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        phase_d     = PH_HEADER;
                        stop_wait_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // a start edge in the same cycle wins over the timeout and freezes the gap count
        if (state_q == S_IDLE && phase_q == PH_PAYLOAD && line) begin
            if (gap_cyc_q == BIT_LAST) begin
                gap_cyc_d = '0;
                if (gap_bits_q == GAP_LAST) begin
                    timeout_d  = 1'b1;
                    phase_d    = PH_HEADER;
                    gap_bits_d = '0;
                end else begin
                    gap_bits_d = gap_bits_q + 1'b1;
                end
            end else begin
                gap_cyc_d = gap_cyc_q + 1'b1;
            end
        end

        timeout_d  = timeout_d & ~frame_err_d;
        overflow_d = pair_done & full & ~pop & ~frame_err_d & ~timeout_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            header_q    <= '0;
            stop_wait_q <= 1'b0;
            phase_q     <= PH_HEADER;
            gap_cyc_q   <= '0;
            gap_bits_q  <= '0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= serial_in;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            header_q    <= header_d;
            stop_wait_q <= stop_wait_d;
            phase_q     <= phase_d;
            gap_cyc_q   <= gap_cyc_d;
            gap_bits_q  <= gap_bits_d;
            frame_err_q <= frame_err_d;
            timeout_q   <= timeout_d;
            overflow_q  <= overflow_d;
        end
    end

    assign pair_valid = (count_q != '0);
    assign full       = (count_q == FULL_COUNT);
    assign pop        = pair_valid & pair_ready;
    assign push       = pair_done & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            hdr_mem[wr_ptr_q] <= header_q;
            pay_mem[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pair_header  = pair_valid ? hdr_mem[rd_ptr_q] : '0;
    assign pair_payload = pair_valid ? pay_mem[rd_ptr_q] : '0;
    assign fifo_count   = count_q;
    assign busy         = (state_q != S_IDLE) | (phase_q == PH_PAYLOAD);
    assign frame_err    = frame_err_q;
    assign timeout_err  = timeout_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_xbar_serial_deframer.sv
// tb/tb_xbar_serial_deframer.sv - self-checking bench for xbar_serial_deframer
module tb_xbar_serial_deframer;

    localparam int PW = 8;
    localparam int BD = 10;
    localparam int FD = 4;
    localparam int GL = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          serial_in = 1'b1;
    logic          ready_man = 1'b0;
    logic          rand_ready = 1'b0;
    logic          rnd_bit = 1'b0;
    logic          pair_ready;
    logic          pair_valid;
    logic [PW-1:0] pair_header, pair_payload;
    logic [$clog2(FD):0] fifo_count;
    logic          busy, frame_err, timeout_err, overflow;

    assign pair_ready = rand_ready ? rnd_bit : ready_man;

    xbar_serial_deframer #(
        .PACKET_WIDTH(PW), .BIT_DIV(BD), .FIFO_DEPTH(FD), .GAP_LIMIT(GL)
    ) dut (
        .clk(clk), .rst(rst), .serial_in(serial_in),
        .pair_valid(pair_valid), .pair_ready(pair_ready),
        .pair_header(pair_header), .pair_payload(pair_payload),
        .fifo_count(fifo_count), .busy(busy), .frame_err(frame_err),
        .timeout_err(timeout_err), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rnd_bit <= ($urandom_range(0, 3) != 0);

    int          checks = 0;
    int          errors = 0;
    int          n_ferr = 0, n_tout = 0, n_ovf = 0;
    time         t_tout = 0;
    logic [15:0] got_q[$];
    logic [15:0] exp_q[$];
    logic        hold_q = 1'b0;
    logic [15:0] hold_v = '0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q && pair_valid)
                check("hold_stable", {pair_header, pair_payload}, hold_v);
            if (pair_valid && pair_ready) got_q.push_back({pair_header, pair_payload});
            if (frame_err) n_ferr++;
            if (timeout_err) begin
                n_tout++;
                t_tout = $time;
            end
            if (overflow) n_ovf++;
            hold_q = pair_valid && !pair_ready;
            hold_v = {pair_header, pair_payload};
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        serial_in = b;
        repeat (BD) tick();
    endtask

    task automatic send_frame(input logic [PW-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < PW; i++) send_bit(d[i]);
        send_bit(stop);
        serial_in = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic clear_obs();
        got_q.delete();
        n_ferr = 0;
        n_tout = 0;
        n_ovf  = 0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_valid"}, pair_valid, 0);
        check({tag, "_header"}, pair_header, 0);
        check({tag, "_payload"}, pair_payload, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_errs"}, {frame_err, timeout_err, overflow}, 0);
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] pay;
        logic       hdr_stop;
        int         gap;
        int         exp_pairs;
        int         exp_ferr;
        int         exp_tout;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'hA5, 8'h3C, 1'b1, 0,  1, 0, 0};
        vecs[1] = '{8'h11, 8'h00, 1'b0, 0,  0, 1, 0};
        vecs[2] = '{8'h22, 8'h33, 1'b1, 0,  1, 0, 0};
        vecs[3] = '{8'h77, 8'h00, 1'b1, 17, 0, 0, 1};
        vecs[4] = '{8'hC3, 8'h5A, 1'b1, 14, 1, 0, 0};
        vecs[5] = '{8'h80, 8'h01, 1'b1, 3,  1, 0, 0};
        vecs[6] = '{8'h00, 8'hFF, 1'b1, 0,  1, 0, 0};

        rst = 1'b1;
        serial_in = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // table vectors: header frame, idle gap, payload (skipped on bad stop or long gap)
        ready_man = 1'b1;
        for (int v = 0; v < 7; v++) begin
            clear_obs();
            send_frame(vecs[v].hdr, vecs[v].hdr_stop);
            if (vecs[v].hdr_stop) begin
                idle_bits(vecs[v].gap);
                if (vecs[v].gap < GL) send_frame(vecs[v].pay, 1'b1);
            end
            idle_bits(3);
            check($sformatf("v%0d_pairs", v), got_q.size(), vecs[v].exp_pairs);
            if (vecs[v].exp_pairs == 1 && got_q.size() == 1)
                check($sformatf("v%0d_pair", v), got_q[0], {vecs[v].hdr, vecs[v].pay});
            check($sformatf("v%0d_ferr", v), n_ferr, vecs[v].exp_ferr);
            check($sformatf("v%0d_tout", v), n_tout, vecs[v].exp_tout);
            check($sformatf("v%0d_ovf", v), n_ovf, 0);
            check($sformatf("v%0d_busy", v), busy, 0);
        end

        // short low glitch in idle is a false start
        clear_obs();
        serial_in = 1'b0;
        repeat (3) tick();
        serial_in = 1'b1;
        idle_bits(2);
        check("glitch_busy", busy, 0);
        check("glitch_ferr", n_ferr, 0);
        send_frame(8'h01, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle_bits(2);
        check("glitch_pairs", got_q.size(), 1);
        if (got_q.size() == 1) check("glitch_pair", got_q[0], 16'h01FF);

        // timeout lands within the 16th bit-time after the header stop bit
        begin
            time t_end;
            int  dcyc;
            clear_obs();
            send_frame(8'h44, 1'b1);
            t_end = $time;
            check("tout_busy_pending", busy, 1);
            idle_bits(17);
            check("tout_count", n_tout, 1);
            dcyc = int'((t_tout - t_end) / 10);
            check("tout_window", (n_tout == 1 && dcyc >= 150 && dcyc <= 170) ? 1 : 0, 1);
            check("tout_busy_after", busy, 0);
            send_frame(8'h55, 1'b1);
            send_frame(8'h66, 1'b1);
            idle_bits(2);
            check("tout_next_pairs", got_q.size(), 1);
            if (got_q.size() == 1) check("tout_next_pair", got_q[0], 16'h5566);
        end

        // overflow: five pairs with consumer stalled
        clear_obs();
        ready_man = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_frame(8'h10 + 8'(i), 1'b1);
            send_frame(8'hE0 + 8'(i), 1'b1);
            idle_bits(1);
            if (i < 4) check($sformatf("ovf_count%0d", i), fifo_count, i + 1);
        end
        check("ovf_count_full", fifo_count, FD);
        check("ovf_pulses", n_ovf, 1);
        check("ovf_head", {pair_header, pair_payload}, 16'h10E0);
        ready_man = 1'b1;
        repeat (10) tick();
        check("ovf_drained", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check($sformatf("ovf_order%0d", i), got_q[i], {8'h10 + 8'(i), 8'hE0 + 8'(i)});
        check("ovf_empty", fifo_count, 0);

        // reset in the middle of a payload with two pairs queued
        clear_obs();
        ready_man = 1'b0;
        send_frame(8'h31, 1'b1);
        send_frame(8'h41, 1'b1);
        send_frame(8'h32, 1'b1);
        send_frame(8'h42, 1'b1);
        idle_bits(1);
        check("rst_pre_count", fifo_count, 2);
        send_frame(8'h9A, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        serial_in = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        serial_in = 1'b1;
        tick();
        check_outputs_zero("midrst");
        rst = 1'b0;
        clear_obs();
        idle_bits(2);
        ready_man = 1'b1;
        send_frame(8'hBE, 1'b1);
        send_frame(8'hEF, 1'b1);
        idle_bits(2);
        check("midrst_pairs", got_q.size(), 1);
        if (got_q.size() == 1) check("midrst_pair", got_q[0], 16'hBEEF);
        check("midrst_errs", n_ferr + n_tout + n_ovf, 0);

        // random traffic against an in-order pair model with a jittery consumer
        clear_obs();
        exp_q.delete();
        rand_ready = 1'b1;
        for (int p = 0; p < 25; p++) begin
            logic [7:0] h, d;
            h = 8'($urandom);
            d = 8'($urandom);
            exp_q.push_back({h, d});
            send_frame(h, 1'b1);
            idle_bits($urandom_range(0, 10));
            send_frame(d, 1'b1);
            idle_bits($urandom_range(0, 4));
        end
        begin
            int k = 0;
            while (got_q.size() < exp_q.size() && k < 4000) begin
                tick();
                k++;
            end
        end
        check("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("rand_pair%0d", i), got_q[i], exp_q[i]);
        check("rand_errs", n_ferr + n_tout + n_ovf, 0);
        rand_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
